// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: recovers the hex value and decimal point of each digit
// of a multiplexed, active-low seven-segment display by watching anode/cathode.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no single digit selected; waiting for a valid anode
//   SETTLE | candidate anode/cathode latched; counting consecutive stable cycles
//   HOLD   | digit captured; ignoring the bus until the anode changes
module seven_segment_decoder #(
  parameter int NUM_SEGMENTS  = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SEGMENTS-1:0]     anode,
  input  logic [7:0]                  cathode,
  output logic [NUM_SEGMENTS*4-1:0]   encoded,
  output logic [NUM_SEGMENTS-1:0]     digit_point,
  output logic [NUM_SEGMENTS-1:0]     digit_seen,
  output logic                        frame_valid,
  output logic                        decode_error
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [7:0] SETTLE_TC = 8'(SETTLE_CYCLES);

  state_t                      state_q, state_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic [NUM_SEGMENTS-1:0]     anode_q;
  logic [7:0]                  cathode_q;
  logic [NUM_SEGMENTS-1:0]     lat_anode_q, lat_anode_d;
  logic [7:0]                  lat_cathode_q, lat_cathode_d;
  logic [NUM_SEGMENTS*4-1:0]   encoded_q, encoded_d;
  logic [NUM_SEGMENTS-1:0]     digit_point_q, digit_point_d;
  logic [NUM_SEGMENTS-1:0]     digit_seen_q, digit_seen_d;
  logic                        frame_valid_q, frame_valid_d;
  logic                        decode_error_q, decode_error_d;

  logic                        capture;
  logic                        anode_ok;
  logic                        pair_same;
  logic [NUM_SEGMENTS-1:0]     seen_nxt;
  logic [4:0]                  dec;

  // Exactly one digit select low; zero or several low means the bus is between digits.
  function automatic logic one_low(input logic [NUM_SEGMENTS-1:0] a);
    int n;
    n = 0;
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      if (!a[i]) n++;
    end
    return (n == 1);
  endfunction

  // Returns {hit, value}; segment order is gfedcba, active-high.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Next-state, settle counter, capture and frame bookkeeping.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lat_anode_d    = lat_anode_q;
    lat_cathode_d  = lat_cathode_q;
    encoded_d      = encoded_q;
    digit_point_d  = digit_point_q;
    digit_seen_d   = digit_seen_q;
    frame_valid_d  = 1'b0;
    decode_error_d = decode_error_q;
    capture        = 1'b0;
    seen_nxt       = digit_seen_q;
    anode_ok       = one_low(anode_q);
    pair_same      = (anode_q == lat_anode_q) && (cathode_q == lat_cathode_q);
    dec            = seg_decode(~lat_cathode_q[6:0]);

    case (state_q)
      IDLE: begin
        if (anode_ok) begin
          state_d       = SETTLE;
          cnt_d         = 8'd1;
          lat_anode_d   = anode_q;
          lat_cathode_d = cathode_q;
        end
      end
      SETTLE: begin
        // The latched pair has already been stable SETTLE_CYCLES samples here,
        // so the current sample no longer matters for this digit.
        if (cnt_q >= SETTLE_TC) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (pair_same) begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else if (anode_ok) begin
          cnt_d         = 8'd1;
          lat_anode_d   = anode_q;
          lat_cathode_d = cathode_q;
        end else begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      HOLD: begin
        if (anode_q != lat_anode_q) begin
          if (anode_ok) begin
            state_d       = SETTLE;
            cnt_d         = 8'd1;
            lat_anode_d   = anode_q;
            lat_cathode_d = cathode_q;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    if (capture) begin
      for (int i = 0; i < NUM_SEGMENTS; i++) begin
        if (!lat_anode_q[i]) begin
          if (dec[4]) encoded_d[i*4 +: 4] = dec[3:0];
          digit_point_d[i] = ~lat_cathode_q[7];
        end
      end
      if (!dec[4]) decode_error_d = 1'b1;
      seen_nxt = digit_seen_q | ~lat_anode_q;
      // A completed frame is reported and the seen mask restarts in the same cycle.
      if (&seen_nxt) begin
        frame_valid_d = 1'b1;
        digit_seen_d  = '0;
      end else begin
        digit_seen_d  = seen_nxt;
      end
    end
  end

  // Input register, FSM and output registers; reset overrides any capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      anode_q        <= '1;
      cathode_q      <= '1;
      lat_anode_q    <= '1;
      lat_cathode_q  <= '1;
      encoded_q      <= '0;
      digit_point_q  <= '0;
      digit_seen_q   <= '0;
      frame_valid_q  <= 1'b0;
      decode_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      anode_q        <= anode;
      cathode_q      <= cathode;
      lat_anode_q    <= lat_anode_d;
      lat_cathode_q  <= lat_cathode_d;
      encoded_q      <= encoded_d;
      digit_point_q  <= digit_point_d;
      digit_seen_q   <= digit_seen_d;
      frame_valid_q  <= frame_valid_d;
      decode_error_q <= decode_error_d;
    end
  end

  assign encoded      = encoded_q;
  assign digit_point  = digit_point_q;
  assign digit_seen   = digit_seen_q;
  assign frame_valid  = frame_valid_q;
  assign decode_error = decode_error_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: a 4-digit instance checked every cycle against a
// timestamp-based reference model, plus a 1-digit, 1-cycle-settle instance.
module tb_seven_segment_decoder;
  localparam int N = 4;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  anode;
  logic [7:0]  cathode;
  logic [15:0] encoded;
  logic [3:0]  digit_point, digit_seen;
  logic        frame_valid, decode_error;

  logic [0:0]  anode1;
  logic [7:0]  cathode1;
  logic [3:0]  encoded1;
  logic [0:0]  digit_point1, digit_seen1;
  logic        frame_valid1, decode_error1;

  seven_segment_decoder #(.NUM_SEGMENTS(N), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .anode(anode), .cathode(cathode),
    .encoded(encoded), .digit_point(digit_point), .digit_seen(digit_seen),
    .frame_valid(frame_valid), .decode_error(decode_error)
  );

  seven_segment_decoder #(.NUM_SEGMENTS(1), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .anode(anode1), .cathode(cathode1),
    .encoded(encoded1), .digit_point(digit_point1), .digit_seen(digit_seen1),
    .frame_valid(frame_valid1), .decode_error(decode_error1)
  );

  int n_vec = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int fv1_cnt = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [0:0] an1_drv = 1'b1;
  logic [7:0] ca1_drv = 8'hFF;

  // Reference model: the input register, a candidate pair with the edge it was
  // first seen, and the anode locked after a capture.
  logic [3:0]  m_an = 4'hF;
  logic [7:0]  m_ca = 8'hFF;
  bit          cand = 0;
  logic [3:0]  cand_an;
  logic [7:0]  cand_ca;
  int          cand_t = 0;
  bit          locked = 0;
  logic [3:0]  lock_an;
  int          t_edge = 0;
  logic [15:0] e_enc = '0;
  logic [3:0]  e_dp = '0, e_seen = '0;
  logic        e_fv = 0, e_err = 0;

  function automatic bit valid_an(input logic [3:0] a);
    return $countones(~a) == 1;
  endfunction

  function automatic logic [7:0] cat(input int k, input bit dp);
    logic [6:0] s;
    s = seg_tab[k];
    return {~dp, ~s};
  endfunction

  task automatic model_capture(input logic [3:0] an, input logic [7:0] ca);
    int d;
    int v;
    d = 0;
    v = -1;
    for (int i = 0; i < N; i++) if (!an[i]) d = i;
    for (int k = 0; k < 16; k++) if (seg_tab[k] == ~ca[6:0]) v = k;
    if (v >= 0) e_enc[d*4 +: 4] = 4'(v);
    else        e_err = 1'b1;
    e_dp[d]   = ~ca[7];
    e_seen[d] = 1'b1;
    if (e_seen == 4'hF) begin
      e_fv   = 1'b1;
      e_seen = '0;
    end
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] an, input logic [7:0] ca);
    t_edge++;
    e_fv = 1'b0;
    if (rst) begin
      e_enc = '0; e_dp = '0; e_seen = '0; e_err = 1'b0;
      cand = 0; locked = 0;
      m_an = 4'hF; m_ca = 8'hFF;
    end else begin
      if (locked) begin
        if (m_an != lock_an) begin
          locked = 0;
          cand   = valid_an(m_an);
          cand_an = m_an; cand_ca = m_ca; cand_t = t_edge;
        end
      end else if (cand && (t_edge - cand_t == S)) begin
        model_capture(cand_an, cand_ca);
        locked  = 1;
        lock_an = cand_an;
        cand    = 0;
      end else if (cand && m_an == cand_an && m_ca == cand_ca) begin
        cand = 1;
      end else begin
        cand    = valid_an(m_an);
        cand_an = m_an; cand_ca = m_ca; cand_t = t_edge;
      end
      m_an = an;
      m_ca = ca;
    end
  endtask

  task automatic check_all();
    n_vec++;
    assert (encoded === e_enc) else begin
      n_err++; $error("FAIL encoded: got %h expected %h (t=%0d)", encoded, e_enc, t_edge);
    end
    n_vec++;
    assert (digit_point === e_dp) else begin
      n_err++; $error("FAIL digit_point: got %b expected %b (t=%0d)", digit_point, e_dp, t_edge);
    end
    n_vec++;
    assert (digit_seen === e_seen) else begin
      n_err++; $error("FAIL digit_seen: got %b expected %b (t=%0d)", digit_seen, e_seen, t_edge);
    end
    n_vec++;
    assert (frame_valid === e_fv) else begin
      n_err++; $error("FAIL frame_valid: got %b expected %b (t=%0d)", frame_valid, e_fv, t_edge);
    end
    n_vec++;
    assert (decode_error === e_err) else begin
      n_err++; $error("FAIL decode_error: got %b expected %b (t=%0d)", decode_error, e_err, t_edge);
    end
    if (frame_valid === 1'b1) fv_cnt++;
    if (frame_valid1 === 1'b1) fv1_cnt++;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++; $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic rst, input logic [3:0] an, input logic [7:0] ca);
    reset    = rst;
    anode    = an;
    cathode  = ca;
    anode1   = an1_drv;
    cathode1 = ca1_drv;
    @(posedge clk);
    model_edge(rst, an, ca);
    @(negedge clk);
    check_all();
  endtask

  task automatic scan(input logic [7:0] c0, input logic [7:0] c1,
                      input logic [7:0] c2, input logic [7:0] c3);
    for (int c = 0; c < 8; c++) tick(0, 4'hE, c0);
    for (int c = 0; c < 8; c++) tick(0, 4'hD, c1);
    for (int c = 0; c < 8; c++) tick(0, 4'hB, c2);
    for (int c = 0; c < 8; c++) tick(0, 4'h7, c3);
  endtask

  initial begin
    logic [15:0] snap_enc;
    logic [3:0]  snap_dp, snap_seen;
    int          lat;

    reset = 1'b1; anode = 4'hF; cathode = 8'hFF; anode1 = 1'b1; cathode1 = 8'hFF;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) tick(1, 4'hF, 8'hFF);
    check_val("rst_encoded", 32'(encoded), 0);
    check_val("rst_seen", 32'(digit_seen), 0);
    check_val("rst_err", 32'(decode_error), 0);

    // Basic scan with latency measurement on digit 0
    fv_cnt = 0;
    lat = 0;
    for (int c = 0; c < 8; c++) begin
      tick(0, 4'hE, 8'hC0);
      if (lat == 0 && digit_seen[0] === 1'b1) lat = c + 1;
    end
    for (int c = 0; c < 8; c++) tick(0, 4'hD, 8'hF9);
    for (int c = 0; c < 8; c++) tick(0, 4'hB, 8'hA4);
    for (int c = 0; c < 8; c++) tick(0, 4'h7, 8'h30);
    check_val("latency", 32'(lat), 32'(1 + S + 1));
    check_val("scan_encoded", 32'(encoded), 32'h3210);
    check_val("scan_dp", 32'(digit_point), 32'b1000);
    check_val("scan_fv_count", 32'(fv_cnt), 1);
    check_val("scan_err", 32'(decode_error), 0);

    // Cathode never stable long enough
    for (int c = 0; c < 18; c++) tick(0, 4'hE, ((c / 3) % 2 == 0) ? 8'hC0 : 8'hF9);
    check_val("unstable_seen", 32'(digit_seen), 0);
    check_val("unstable_encoded", 32'(encoded), 32'h3210);

    // Unrecognised pattern
    for (int c = 0; c < 8; c++) tick(0, 4'hE, 8'hFF);
    check_val("bad_err", 32'(decode_error), 1);
    check_val("bad_enc0", 32'(encoded[3:0]), 0);
    check_val("bad_seen0", 32'(digit_seen[0]), 1);

    // Two digits selected at once
    snap_enc = encoded; snap_dp = digit_point; snap_seen = digit_seen;
    for (int c = 0; c < 20; c++) tick(0, 4'hC, 8'hC0);
    check_val("multi_enc", 32'(encoded), 32'(snap_enc));
    check_val("multi_dp", 32'(digit_point), 32'(snap_dp));
    check_val("multi_seen", 32'(digit_seen), 32'(snap_seen));
    check_val("err_sticky", 32'(decode_error), 1);

    // Reset during SETTLE of digit 2
    tick(1, 4'hF, 8'hFF);
    for (int c = 0; c < 8; c++) tick(0, 4'hE, cat(5, 0));
    for (int c = 0; c < 8; c++) tick(0, 4'hD, cat(6, 1));
    for (int c = 0; c < 3; c++) tick(0, 4'hB, cat(7, 0));
    tick(1, 4'hB, cat(7, 0));
    check_val("midrst_enc", 32'(encoded), 0);
    check_val("midrst_dp", 32'(digit_point), 0);
    check_val("midrst_seen", 32'(digit_seen), 0);
    check_val("midrst_err", 32'(decode_error), 0);
    fv_cnt = 0;
    scan(8'hC0, 8'hF9, 8'hA4, 8'h30);
    check_val("midrst_fv_count", 32'(fv_cnt), 1);

    // Re-entry of digit 0 within one frame
    tick(1, 4'hF, 8'hFF);
    fv_cnt = 0;
    for (int c = 0; c < 8; c++) tick(0, 4'hE, cat(8, 0));
    for (int c = 0; c < 8; c++) tick(0, 4'hF, 8'hFF);
    scan(cat(9, 0), cat(10, 0), cat(11, 0), cat(12, 0));
    check_val("reentry_enc", 32'(encoded), 32'hCBA9);
    check_val("reentry_fv_count", 32'(fv_cnt), 1);

    // Randomised traffic against the model
    for (int r = 0; r < 70; r++) begin
      int          len;
      logic [3:0]  an_r;
      logic [7:0]  ca_r;
      len = int'($urandom_range(1, 10));
      if ($urandom_range(0, 9) < 8) an_r = ~(4'b0001 << $urandom_range(0, 3));
      else                          an_r = 4'($urandom);
      if ($urandom_range(0, 3) != 0) ca_r = cat(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else                           ca_r = 8'($urandom);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 11) == 0) ca_r = cat(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        tick(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0, an_r, ca_r);
      end
    end

    // Single digit, single settle cycle: every capture completes a frame
    tick(1, 4'hF, 8'hFF);
    for (int k = 0; k < 16; k += 3) begin
      fv1_cnt = 0;
      an1_drv = 1'b0;
      ca1_drv = cat(k, 0);
      for (int c = 0; c < 5; c++) tick(0, 4'hF, 8'hFF);
      an1_drv = 1'b1;
      for (int c = 0; c < 2; c++) tick(0, 4'hF, 8'hFF);
      check_val("n1_encoded", 32'(encoded1), 32'(k));
      check_val("n1_fv_count", 32'(fv1_cnt), 1);
      check_val("n1_seen", 32'(digit_seen1), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
